// File: rtl/tl_ul_reg_responder_pkg.sv
// Shared TileLink-UL definitions for the register responder: opcode
// constants, the registered D-channel response record and the helper
// that maps a transfer size and address offset to the byte lanes it covers.
package tl_ul_pkg;

    // A-channel opcodes serviced by the responder
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // Widest source ID the response record can carry; narrower IDs are zero-extended
    localparam int SRC_W_MAX = 16;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           size;
        logic [SRC_W_MAX-1:0] source;
        logic                 denied;
        logic [31:0]          data;
        logic                 corrupt;
    } d_rsp_t;

    // Byte lanes touched by a naturally aligned access of 2^size bytes
    function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << addr_lo;
            3'd1:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tl_ul_reg_responder_dec.sv
// Combinational request decoder: decides whether an A-channel request is
// legal for this register bank and produces the byte enables a write applies.
module tl_ul_reg_responder_dec
    import tl_ul_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic [2:0]        opcode,
    input  logic [2:0]        param,
    input  logic [2:0]        size,
    input  logic [ADDR_W-1:0] address,
    input  logic [3:0]        mask,
    output logic              denied,
    output logic              is_get,
    output logic [3:0]        byte_en
);

    // One past the last valid byte address, one bit wider so DEPTH*4 == 2^ADDR_W fits
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);

    logic [3:0] lanes;
    logic       op_ok;
    logic       size_ok;
    logic       align_ok;
    logic       range_ok;
    logic       param_ok;
    logic       mask_ok;

    // Evaluate every legality rule and derive the write byte enables
    always_comb begin
        lanes    = lane_mask(size, address[1:0]);
        op_ok    = (opcode == PUT_FULL) || (opcode == PUT_PARTIAL) || (opcode == GET);
        size_ok  = (size <= 3'd2);
        case (size)
            3'd0:    align_ok = 1'b1;
            3'd1:    align_ok = ~address[0];
            default: align_ok = (address[1:0] == 2'b00);
        endcase
        range_ok = ({1'b0, address} < ADDR_LIMIT);
        param_ok = (param == 3'd0);
        case (opcode)
            PUT_FULL:    mask_ok = (mask == lanes);
            PUT_PARTIAL: mask_ok = ((mask & ~lanes) == 4'b0000);
            default:     mask_ok = 1'b1;
        endcase
        denied  = ~(op_ok & size_ok & align_ok & range_ok & param_ok & mask_ok);
        is_get  = (opcode == GET);
        byte_en = (!denied && !is_get) ? mask : 4'b0000;
    end

endmodule

// File: rtl/tl_ul_reg_responder.sv
// TileLink-UL register responder: a bank of DEPTH 32-bit words serviced by
// Get / PutFullData / PutPartialData, with a one-entry response register on D.
// Optional feature macro TL_UL_REG_RESPONDER_STATS_EN adds saturating
// stat_ok / stat_denied counters of completed responses.
module tl_ul_reg_responder
    import tl_ul_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int SRC_W  = 5,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [2:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_mask,
    input  logic [31:0]       a_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [2:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic              d_sink,
    output logic              d_denied,
    output logic [31:0]       d_data,
    output logic              d_corrupt
`ifdef TL_UL_REG_RESPONDER_STATS_EN
    ,
    output logic [15:0]       stat_ok,
    output logic [15:0]       stat_denied
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg;
    d_rsp_t           rsp_reg;
    d_rsp_t           rsp_next;
    logic [31:0]      bank_reg [DEPTH];

    logic             a_fire;
    logic             d_fire;
    logic             denied;
    logic             is_get;
    logic [3:0]       byte_en;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic             src_pad_unused;

    tl_ul_reg_responder_dec #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .opcode  (a_opcode),
        .param   (a_param),
        .size    (a_size),
        .address (a_address),
        .mask    (a_mask),
        .denied  (denied),
        .is_get  (is_get),
        .byte_en (byte_en)
    );

    // A is accepted whenever the response slot is free or being drained this cycle
    assign a_ready  = (state_reg == EMPTY) | d_ready;
    assign a_fire   = a_valid & a_ready;
    assign d_fire   = d_valid & d_ready;

    assign word_idx = a_address[IDX_W+1:2];
    assign rd_word  = bank_reg[word_idx];

    // Build the response for the request on A; read data is sampled before any write lands
    always_comb begin
        rsp_next         = '0;
        rsp_next.opcode  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        rsp_next.size    = a_size;
        rsp_next.source  = SRC_W_MAX'(a_source);
        rsp_next.denied  = denied;
        rsp_next.data    = (is_get && !denied) ? rd_word : 32'd0;
        rsp_next.corrupt = is_get & denied;
    end

    // Response slot FSM: load on A fire, free on D fire, hold while stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= EMPTY;
            rsp_reg   <= '0;
        end else if (a_fire) begin
            state_reg <= FULL;
            rsp_reg   <= rsp_next;
        end else if (d_fire) begin
            state_reg <= EMPTY;
            rsp_reg   <= '0;
        end
    end

    // Register bank: each word commits only its enabled byte lanes on a legal Put
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic wr_hit;
            assign wr_hit = a_fire && (word_idx == IDX_W'(gi));

            // Byte-lane write into word gi
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    bank_reg[gi] <= '0;
                end else if (wr_hit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byte_en[b]) begin
                            bank_reg[gi][8*b +: 8] <= a_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    assign d_valid   = (state_reg == FULL);
    assign d_opcode  = rsp_reg.opcode;
    assign d_param   = 2'b00;
    assign d_size    = rsp_reg.size;
    assign d_source  = rsp_reg.source[SRC_W-1:0];
    assign d_sink    = 1'b0;
    assign d_denied  = rsp_reg.denied;
    assign d_data    = rsp_reg.data;
    assign d_corrupt = rsp_reg.corrupt;

    // Zero-extension bits of the stored source ID are never read back
    assign src_pad_unused = ^rsp_reg.source;

`ifdef TL_UL_REG_RESPONDER_STATS_EN
    logic [15:0] stat_ok_reg;
    logic [15:0] stat_denied_reg;

    // Saturating counts of completed responses, split by outcome
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_ok_reg     <= '0;
            stat_denied_reg <= '0;
        end else if (d_fire) begin
            if (rsp_reg.denied) begin
                if (stat_denied_reg != 16'hFFFF) stat_denied_reg <= stat_denied_reg + 16'd1;
            end else begin
                if (stat_ok_reg != 16'hFFFF) stat_ok_reg <= stat_ok_reg + 16'd1;
            end
        end
    end

    assign stat_ok     = stat_ok_reg;
    assign stat_denied = stat_denied_reg;
`endif

endmodule

// File: tb/tb_tl_ul_reg_responder.sv
// Self-checking bench for tl_ul_reg_responder: directed scenarios followed
// by randomized traffic, all checked against a transaction-level model.
module tb_tl_ul_reg_responder;

    localparam int DEPTH  = 16;
    localparam int SRC_W  = 5;
    localparam int ADDR_W = 15;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic [2:0]        a_opcode = '0;
    logic [2:0]        a_param = '0;
    logic [2:0]        a_size = '0;
    logic [SRC_W-1:0]  a_source = '0;
    logic [ADDR_W-1:0] a_address = '0;
    logic [3:0]        a_mask = '0;
    logic [31:0]       a_data = '0;
    logic              d_valid;
    logic              d_ready = 1'b0;
    logic [2:0]        d_opcode;
    logic [1:0]        d_param;
    logic [2:0]        d_size;
    logic [SRC_W-1:0]  d_source;
    logic              d_sink;
    logic              d_denied;
    logic [31:0]       d_data;
    logic              d_corrupt;
`ifdef TL_UL_REG_RESPONDER_STATS_EN
    logic [15:0]       stat_ok;
    logic [15:0]       stat_denied;
`endif

    tl_ul_reg_responder #(
        .DEPTH  (DEPTH),
        .SRC_W  (SRC_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt)
`ifdef TL_UL_REG_RESPONDER_STATS_EN
        ,
        .stat_ok     (stat_ok),
        .stat_denied (stat_denied)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model state
    int unsigned mem [DEPTH];
    bit          exp_full;
    int          exp_op, exp_size, exp_src, exp_den, exp_cor;
    int unsigned exp_data;
    int          model_ok, model_den;
    int          ready_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int tb_lanes(input int size, input int addr);
        int nb;
        nb = 1 << size;
        return ((1 << nb) - 1) << (addr % 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        exp_full  = 0;
        model_ok  = 0;
        model_den = 0;
    endtask

    // One clock cycle: drive A/D inputs, check outputs against the model, advance the model
    task automatic cycle(input bit av, input int op, input int prm, input int sz, input int src,
                         input int addr, input int msk, input int unsigned dat, input bit dr);
        bit af, df, den;
        int nb, lanes, w;
        @(negedge clock);
        a_valid   = av;
        a_opcode  = 3'(op);
        a_param   = 3'(prm);
        a_size    = 3'(sz);
        a_source  = SRC_W'(src);
        a_address = ADDR_W'(addr);
        a_mask    = 4'(msk);
        a_data    = dat;
        d_ready   = dr;
        #1;
        check("a_ready", a_ready, (!exp_full || dr) ? 32'd1 : 32'd0);
        check("d_valid", d_valid, exp_full ? 32'd1 : 32'd0);
        if (a_ready) ready_seen++;
        if (exp_full) begin
            check("d_opcode", d_opcode, exp_op);
            check("d_size", d_size, exp_size);
            check("d_source", d_source, exp_src);
            check("d_denied", d_denied, exp_den);
            check("d_data", d_data, exp_data);
            check("d_corrupt", d_corrupt, exp_cor);
            check("d_param", d_param, 0);
            check("d_sink", d_sink, 0);
        end
        af = av && (!exp_full || dr);
        df = exp_full && dr;
        if (df) begin
            $display("txn D op=%0d src=%0d denied=%0d data=%08h", exp_op, exp_src, exp_den, exp_data);
            if (exp_den != 0) begin
                if (model_den < 65535) model_den++;
            end else begin
                if (model_ok < 65535) model_ok++;
            end
            exp_full = 0;
        end
        if (af) begin
            den = 0;
            if (!(op == 0 || op == 1 || op == 4)) den = 1;
            if (sz > 2) den = 1;
            if (prm != 0) den = 1;
            if (addr >= DEPTH * 4) den = 1;
            lanes = 0;
            if (sz <= 2) begin
                nb = 1 << sz;
                if (addr % nb != 0) den = 1;
                lanes = tb_lanes(sz, addr);
            end
            if (op == 0 && msk != lanes) den = 1;
            if (op == 1 && (msk & ~lanes & 15) != 0) den = 1;
            w = (addr / 4) % DEPTH;
            exp_full = 1;
            exp_op   = (op == 4) ? 1 : 0;
            exp_size = sz;
            exp_src  = src;
            exp_den  = den;
            exp_cor  = (op == 4 && den) ? 1 : 0;
            exp_data = (op == 4 && !den) ? mem[w] : 0;
            if (!den && op != 4) begin
                for (int b = 0; b < 4; b++) begin
                    if (msk[b]) begin
                        mem[w] = (mem[w] & ~(32'hFF << (8 * b))) | (dat & (32'hFF << (8 * b)));
                    end
                end
            end
        end
    endtask

    task automatic idle(input bit dr);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, dr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, sz, addr, msk, r;
        model_reset();

        // Reset state
        #12;
        check("rst_d_valid", d_valid, 0);
        check("rst_d_opcode", d_opcode, 0);
        check("rst_d_data", d_data, 0);
        check("rst_d_source", d_source, 0);
        check("rst_d_denied", d_denied, 0);
        check("rst_d_corrupt", d_corrupt, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // PutFull then Get of the same word
        cycle(1, 0, 0, 2, 3, 'h8, 'hF, 32'hDEADBEEF, 1);
        cycle(1, 4, 0, 2, 5, 'h8, 'hF, 0, 1);
        check("put_ack_opcode", d_opcode, 0);
        idle(1);
        check("get_data", d_data, 32'hDEADBEEF);
        check("get_source", d_source, 5);
        check("get_opcode", d_opcode, 1);

        // PutPartial into one byte lane
        cycle(1, 0, 0, 2, 1, 'h8, 'hF, 32'h11223344, 1);
        cycle(1, 1, 0, 0, 1, 'h9, 'h2, 32'h0000AA00, 1);
        cycle(1, 4, 0, 2, 2, 'h8, 'hF, 0, 1);
        idle(1);
        check("partial_data", d_data, 32'h1122AA44);

        // Out-of-range Get and misaligned PutFull are denied with no side effect
        cycle(1, 4, 0, 2, 7, DEPTH * 4, 'hF, 0, 1);
        cycle(1, 0, 0, 2, 8, 'h2, 'hF, 32'hCAFEF00D, 1);
        check("oor_denied", d_denied, 1);
        check("oor_corrupt", d_corrupt, 1);
        check("oor_data", d_data, 0);
        cycle(1, 4, 0, 2, 9, 'h0, 'hF, 0, 1);
        check("misalign_denied", d_denied, 1);
        idle(1);
        check("bank_unchanged", d_data, 32'h0);

        // Backpressure: first request accepted, then a_ready low while stalled
        idle(1);
        for (int i = 0; i < 6; i++) cycle(1, 4, 0, 2, 10 + i, 'h8, 'hF, 0, 0);
        check("stall_a_ready", a_ready, 0);
        ready_seen = 0;
        for (int i = 0; i < 8; i++) cycle(1, 4, 0, 2, i, 4 * i, 'hF, 0, 1);
        check("no_bubbles", ready_seen, 8);
        idle(1);
        idle(1);

        // Asynchronous reset while a response is pending
        cycle(1, 4, 0, 2, 4, 'h8, 'hF, 0, 0);
        idle(0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_d_valid", d_valid, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1, 4, 0, 2, 6, 'h8, 'hF, 0, 1);
        idle(1);
        check("bank_cleared", d_data, 0);
        idle(1);

        // Three legal and two illegal requests after a fresh reset
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1, 0, 0, 2, 1, 'h0, 'hF, 32'h01020304, 1);
        cycle(1, 4, 0, 2, 2, 'h4, 'hF, 0, 1);
        cycle(1, 1, 0, 2, 3, 'h0, 'h0, 32'hFFFFFFFF, 1);
        cycle(1, 2, 0, 2, 4, 'h0, 'hF, 0, 1);
        cycle(1, 4, 1, 2, 5, 'h0, 'hF, 0, 1);
        idle(1);
        idle(1);
`ifdef TL_UL_REG_RESPONDER_STATS_EN
        check("stat_ok_3", stat_ok, 3);
        check("stat_denied_2", stat_denied, 2);
`endif
        cycle(1, 4, 0, 2, 6, 'h0, 'hF, 0, 1);
        idle(1);
        check("mask0_no_write", d_data, 32'h01020304);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 4 : $urandom_range(0, 7);
            sz = ($urandom_range(0, 15) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
            addr = $urandom_range(0, DEPTH * 4 + 7);
            if ($urandom_range(0, 7) != 0 && sz <= 2) addr = addr & ~((1 << sz) - 1);
            msk = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1 && sz <= 2) begin
                msk = tb_lanes(sz, addr) & 15;
                if (op == 1) msk = msk & $urandom_range(0, 15);
            end
            cycle($urandom_range(0, 3) != 0, op, ($urandom_range(0, 19) == 0) ? 1 : 0, sz,
                  $urandom_range(0, 31), addr, msk, $urandom, $urandom_range(0, 9) < 7);
        end
        idle(1);
        idle(1);
`ifdef TL_UL_REG_RESPONDER_STATS_EN
        check("stat_ok_final", stat_ok, model_ok);
        check("stat_denied_final", stat_denied, model_den);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_ul_reg_responder.md
Name: tl_ul_reg_responder

Overview:
- TileLink-UL slave (responder) terminating one A/D channel pair. It is the far end of the interface our TL monitors check on the initiator side.
- Holds a small 32-bit register bank and services Get, PutFullData and PutPartialData.
- Returns AccessAckData or AccessAck on D, with full A/D backpressure.
- Sits behind the peripheral crossbar as a scratch/config register target.

Parameters:
- DEPTH, 16, number of 32-bit words; power of two, 2..256.
- SRC_W, 5, source ID width.
- ADDR_W, 15, address width; must satisfy 2^ADDR_W >= DEPTH*4.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  A request valid.
- a_ready  out  1  A request accepted when a_valid & a_ready.
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get.
- a_param  in  3  ignored; must be 0.
- a_size  in  3  log2 bytes.
- a_source  in  SRC_W  request ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- d_valid  out  1  response valid.
- d_ready  in  1  response accepted.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  3  echo of a_size.
- d_source  out  SRC_W  echo of a_source.
- d_sink  out  1  always 0.
- d_denied  out  1  request illegal; no side effect.
- d_data  out  32  read data; 0 when not AccessAckData or when denied.
- d_corrupt  out  1  equals d_denied for AccessAckData, 0 otherwise.

Behaviour:
- Reset: asynchronous assertion clears every output register to 0, so d_valid=0 and all d_* fields=0. a_ready=1 once reset_n is high. Register bank clears to 0.
- Reset mid-response: pending response is discarded and d_valid drops without a handshake.
- States:
  - EMPTY: d_valid=0.
  - FULL: d_valid=1, holding one response.
- Accept rule: a_ready = EMPTY | d_ready, giving one request per cycle at full throughput. a_ready must not depend on a_valid.
- Transitions:
  - EMPTY + A fire -> FULL.
  - FULL + D fire, no A fire -> EMPTY.
  - FULL + D fire + A fire in the same cycle -> FULL with the new response loaded.
  - FULL + !d_ready -> hold; all d_* fields stay stable.
- Latency: response is visible one cycle after A fire.
- Legality: a request is denied if any of the following holds:
  - opcode is not in {0, 1, 4};
  - a_size > 2;
  - a_address is not aligned to a_size;
  - a_address >= DEPTH*4;
  - a_param != 0;
  - PutFull mask != the lanes implied by a_size and a_address[1:0];
  - PutPartial mask has bits outside those lanes.
- Get mask is not checked.
- Writes:
  - Commit on the A fire edge, only the enabled byte lanes, only if not denied.
  - PutPartial with mask=0 is legal; it acks and writes nothing.
- Reads:
  - Sample word a_address[ADDR_W-1:2] at the A fire edge and return the full 32-bit word on every lane.
  - Read-after-write in back-to-back cycles returns the new data.
- d_opcode: 1 for Get, 0 for Put, including when denied.

Optional Feature:
- Macro TL_UL_REG_RESPONDER_STATS_EN.
- Defined:
  - Adds outputs stat_ok [15:0] and stat_denied [15:0].
  - Each increments on D fire of a non-denied or denied response respectively.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package tl_ul_pkg:
  - A opcode constants: PUT_FULL=3'd0, PUT_PARTIAL=3'd1, GET=3'd4.
  - D opcode constants: ACCESS_ACK=3'd0, ACCESS_ACK_DATA=3'd1.
  - Packed D-response struct (opcode, size, source, denied, data, corrupt).
  - Lane-mask function mapping size and addr[1:0] to a 4-bit mask.
- Sub-module tl_ul_reg_responder_dec: purely combinational legality check and lane-mask generation. The top module holds the bank and the FSM.

Test Plan:
- Reset, then PutFull addr 0x8 size 2 mask F data 0xDEADBEEF, then Get 0x8 source 5 -> AccessAck, then AccessAckData d_data=0xDEADBEEF, d_source=5, d_denied=0; each response one cycle after its A fire.
- PutPartial addr 0x9 size 0 mask 0x2 data 0x0000AA00 on a word holding 0x11223344, then Get -> 0x1122AA44.
- Get addr DEPTH*4 (0x40), then PutFull addr 0x2 size 2 -> both responses have d_denied=1; Get returns d_data=0, d_corrupt=1; bank unchanged.
- Hold d_ready=0 for 5 cycles with a_valid high -> a_ready=0 after the first accept; D fields stable. Then d_ready=1 for continuous traffic -> one fire per cycle with no bubbles.
- Assert reset_n low while d_valid=1 -> d_valid=0 immediately (asynchronous); bank reads 0 after release.
- With TL_UL_REG_RESPONDER_STATS_EN: 3 legal and 2 illegal requests -> stat_ok=3, stat_denied=2.
